// File: rtl/cam_capture.sv
// Camera capture front end: packs registered 8-bit camera bytes into RGB565 pixels tagged sof/eol.
// Latency: pixel enters the holding register 1 cycle after its 2nd byte; it is visible on pix_* 1 cycle after its push.
// Backpressure: pix_valid/pix_ready; a pixel pushed into a full FIFO is dropped and sets sticky overflow.
// Optional feature: define CAM_CAPTURE_DECIMATE_EN for 2:1 decimation in both axes.

// Small generic first-word-fall-through FIFO; head_dat is valid whenever empty is low.
module cam_capture_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  // Pointer update; the caller only pushes when there is room (or a pop frees it).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; on full+pop the slot written is the one being read out this cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module cam_capture #(
  parameter int FIFO_DEPTH = 4,
  parameter int LINE_CNT_W = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            cam_dat,
  input  logic                  cam_href,
  input  logic                  cam_vsync,
  output logic [15:0]           pix_data,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  frame_done,
  output logic [LINE_CNT_W-1:0] line_count,
  output logic                  overflow,
  input  logic                  overflow_clr
);
  localparam logic [LINE_CNT_W-1:0] LC_ONE = 1;
  localparam logic [LINE_CNT_W-1:0] LC_MAX = '1;

  typedef enum logic [1:0] {SYNC_WAIT, SYNC_LOW, FRAME} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        href_q;
  logic        vsync_q;
  logic        phase;
  logic        sof_arm;
  logic [7:0]  hi_byte;
  logic        held_vld;
  logic        held_sof;
  logic [15:0] held_dat;

  logic        enter_frame;
  logic        vs_rise;
  logic        href_fall;
  logic        line_end;
  logic        byte_acc;
  logic        pix_done;
  logic        keep;

  logic        push_req;
  logic [17:0] push_dat;
  logic        push_ok;
  logic        drop;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [17:0] head_dat;

  // Frame-sync state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SYNC_WAIT;
    else       state <= state_nxt;
  end

  // Next state plus per-cycle frame events; bytes only count inside FRAME.
  always_comb begin
    state_nxt   = state;
    enter_frame = 1'b0;
    vs_rise     = 1'b0;
    href_fall   = 1'b0;
    byte_acc    = 1'b0;
    case (state)
      SYNC_WAIT: begin
        if (cam_vsync) state_nxt = SYNC_LOW;
      end
      SYNC_LOW: begin
        if (!cam_vsync) begin
          state_nxt   = FRAME;
          enter_frame = 1'b1;
        end
      end
      FRAME: begin
        vs_rise   = cam_vsync & ~vsync_q;
        href_fall = href_q & ~cam_href;
        byte_acc  = cam_href & ~cam_vsync;
        if (vs_rise) state_nxt = SYNC_LOW;
      end
      default: state_nxt = SYNC_WAIT;
    endcase
  end

  // A line ends on href fall, or abruptly when vsync rises mid-line.
  assign line_end = href_fall | vs_rise;
  assign pix_done = byte_acc & phase;

`ifdef CAM_CAPTURE_DECIMATE_EN
  logic pix_odd;

  // In-line pixel index parity; only even pixels of even lines survive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       pix_odd <= 1'b0;
    else if (enter_frame | line_end) pix_odd <= 1'b0;
    else if (pix_done)               pix_odd <= ~pix_odd;
  end

  assign keep = ~line_count[0] & ~pix_odd;
`else
  assign keep = 1'b1;
`endif

  // Registered copies of href/vsync for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      href_q  <= cam_href;
      vsync_q <= cam_vsync;
    end
  end

  // Push selection: the held pixel leaves with eol at line end, or without eol when displaced by a newer pixel.
  always_comb begin
    push_req = 1'b0;
    push_dat = '0;
    if (line_end && held_vld) begin
      push_req = 1'b1;
      push_dat = {held_sof, 1'b1, held_dat};
    end else if (pix_done && keep && held_vld) begin
      push_req = 1'b1;
      push_dat = {held_sof, 1'b0, held_dat};
    end
  end

  assign pop     = ~fifo_empty & pix_ready;
  assign push_ok = push_req & (~fifo_full | pop);
  assign drop    = push_req & ~push_ok;

  // Byte packing, one-pixel holding register, sof arming and line counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= 1'b0;
      sof_arm    <= 1'b0;
      hi_byte    <= '0;
      held_vld   <= 1'b0;
      held_sof   <= 1'b0;
      held_dat   <= '0;
      line_count <= '0;
    end else if (enter_frame) begin
      phase      <= 1'b0;
      sof_arm    <= 1'b1;
      held_vld   <= 1'b0;
      line_count <= '0;
    end else if (line_end) begin
      // Any dangling high byte is discarded here.
      phase    <= 1'b0;
      held_vld <= 1'b0;
      if (href_fall && (line_count != LC_MAX)) line_count <= line_count + LC_ONE;
    end else if (byte_acc) begin
      if (!phase) begin
        hi_byte <= cam_dat;
        phase   <= 1'b1;
      end else begin
        phase <= 1'b0;
        if (keep) begin
          held_vld <= 1'b1;
          held_dat <= {hi_byte, cam_dat};
          held_sof <= sof_arm;
          sof_arm  <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow (a drop beats a clear) and the frame-end pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= vs_rise;
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  cam_capture_fifo #(
    .W     (18),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_ok),
    .push_dat (push_dat),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head_dat)
  );

  // Outputs read as zero while the FIFO is empty.
  assign pix_valid = ~fifo_empty;
  assign {pix_sof, pix_eol, pix_data} = pix_valid ? head_dat : 18'h0;
endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture: sync gating, packing, eol/sof tagging, overflow and full-with-pop.
// Latency: outputs are sampled at the falling edge; accepted pixels are collected into a queue.
// Backpressure: pix_ready is driven per test to fill, stall and drain the FIFO.
module tb_cam_capture;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cam_dat;
  logic        cam_href;
  logic        cam_vsync;
  logic [15:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_valid;
  logic        pix_ready;
  logic        frame_done;
  logic [9:0]  line_count;
  logic        overflow;
  logic        overflow_clr;

  int          n_chk = 0;
  int          n_pass = 0;
  int          valid_cnt = 0;
  int          fd_cnt = 0;
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];
  logic [7:0]  byte_q[$];

  always #5 clk = ~clk;

  cam_capture #(
    .FIFO_DEPTH (4),
    .LINE_CNT_W (10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cam_dat      (cam_dat),
    .cam_href     (cam_href),
    .cam_vsync    (cam_vsync),
    .pix_data     (pix_data),
    .pix_sof      (pix_sof),
    .pix_eol      (pix_eol),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .frame_done   (frame_done),
    .line_count   (line_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  // Output monitor: collect accepted pixels, count valid cycles and frame_done pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (pix_valid) valid_cnt++;
      if (pix_valid && pix_ready) got_q.push_back({pix_sof, pix_eol, pix_data});
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] px(input logic sof, input logic eol, input logic [15:0] d);
    return {sof, eol, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input logic [7:0] d, input logic h, input logic v);
    cam_dat   = d;
    cam_href  = h;
    cam_vsync = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(8'h00, 1'b0, 1'b0);
  endtask

  task automatic vsync_pulse();
    repeat (3) cyc(8'h00, 1'b0, 1'b1);
    idle(2);
  endtask

  task automatic send_line();
    foreach (byte_q[i]) cyc(byte_q[i], 1'b1, 1'b0);
    idle(3);
  endtask

  task automatic check_out(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, "_cnt"}, got_q.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_%0d", tag, i), (i < got_q.size()) ? got_q[i] : 18'h3FFFF, exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset        = 1'b1;
    cam_dat      = 8'h00;
    cam_href     = 1'b0;
    cam_vsync    = 1'b0;
    pix_ready    = 1'b1;
    overflow_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", pix_valid, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_sof", pix_sof, 0);
    chk("rst_eol", pix_eol, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_line_count", line_count, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;

    // Bus activity before any vsync must be ignored.
    for (int i = 0; i < 8; i++) cyc(8'hE0 + 8'(i), i[0], 1'b0);
    repeat (3) cyc(8'h00, 1'b0, 1'b1);
    chk("no_valid_before_sync", valid_cnt, 0);
    idle(2);
    got_q.delete();

`ifdef CAM_CAPTURE_DECIMATE_EN
    for (int l = 0; l < 4; l++) begin
      byte_q.delete();
      for (int k = 0; k < 8; k++) byte_q.push_back(8'(l * 16 + k));
      send_line();
    end
    idle(4);
    exp_q.push_back(px(1'b1, 1'b0, 16'h0001));
    exp_q.push_back(px(1'b0, 1'b1, 16'h0405));
    exp_q.push_back(px(1'b0, 1'b0, 16'h2021));
    exp_q.push_back(px(1'b0, 1'b1, 16'h2425));
    check_out("decim");
    chk("decim_line_count", line_count, 4);
`else
    // Two lines of six bytes, consumer always ready.
    byte_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    send_line();
    send_line();
    idle(4);
    exp_q.push_back(px(1'b1, 1'b0, 16'h1234));
    exp_q.push_back(px(1'b0, 1'b0, 16'h5678));
    exp_q.push_back(px(1'b0, 1'b1, 16'h9ABC));
    exp_q.push_back(px(1'b0, 1'b0, 16'h1234));
    exp_q.push_back(px(1'b0, 1'b0, 16'h5678));
    exp_q.push_back(px(1'b0, 1'b1, 16'h9ABC));
    check_out("frame");
    chk("frame_line_count", line_count, 2);
    fd_cnt = 0;
    vsync_pulse();
    chk("frame_done_pulses", fd_cnt, 1);

    // Odd-length line: fifth byte discarded, next line restarts at phase 0.
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_line();
    byte_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_line();
    idle(4);
    exp_q.push_back(px(1'b1, 1'b0, 16'h1122));
    exp_q.push_back(px(1'b0, 1'b1, 16'h3344));
    exp_q.push_back(px(1'b0, 1'b0, 16'hA1A2));
    exp_q.push_back(px(1'b0, 1'b1, 16'hA3A4));
    check_out("odd");
    chk("odd_line_count", line_count, 2);

    // Overflow: 6 pixels into a 4-deep FIFO with the consumer stalled.
    vsync_pulse();
    pix_ready = 1'b0;
    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
               8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    send_line();
    idle(2);
    chk("ovf_set", overflow, 1);
    chk("ovf_valid", pix_valid, 1);
    pix_ready = 1'b1;
    idle(8);
    exp_q.push_back(px(1'b1, 1'b0, 16'h0102));
    exp_q.push_back(px(1'b0, 1'b0, 16'h0304));
    exp_q.push_back(px(1'b0, 1'b0, 16'h0506));
    exp_q.push_back(px(1'b0, 1'b0, 16'h0708));
    check_out("ovf");
    chk("ovf_sticky", overflow, 1);
    overflow_clr = 1'b1;
    idle(1);
    overflow_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Full FIFO: the eol push coincides with a single pop and must be accepted.
    vsync_pulse();
    pix_ready = 1'b0;
    byte_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
               8'h26, 8'h27, 8'h28, 8'h29, 8'h2A};
    foreach (byte_q[i]) cyc(byte_q[i], 1'b1, 1'b0);
    pix_ready = 1'b1;
    cyc(8'h00, 1'b0, 1'b0);
    pix_ready = 1'b0;
    idle(2);
    chk("fullpop_no_ovf", overflow, 0);
    chk("fullpop_valid", pix_valid, 1);
    pix_ready = 1'b1;
    idle(8);
    exp_q.push_back(px(1'b1, 1'b0, 16'h2122));
    exp_q.push_back(px(1'b0, 1'b0, 16'h2324));
    exp_q.push_back(px(1'b0, 1'b0, 16'h2526));
    exp_q.push_back(px(1'b0, 1'b0, 16'h2728));
    exp_q.push_back(px(1'b0, 1'b1, 16'h292A));
    check_out("fullpop");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cam_capture.md
# cam_capture

Camera capture front end sitting directly downstream of the camera pad registers. It consumes the registered 8-bit camera bus with `href`/`vsync` and packs byte pairs into 16-bit RGB565 pixels. It tags start-of-frame and end-of-line, and buffers pixels in a small FIFO. A valid/ready stream feeds the frame-buffer writer.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: pixel FIFO entries; must be a power of 2, minimum 2.
- `LINE_CNT_W`, 10: width of the line counter.

Ports:
- `clk` in 1: camera pixel clock, which is also the bus sample clock. One clock only.
- `reset` in 1: asynchronous, active-high reset.
- `cam_dat` in 8: registered camera data byte.
- `cam_href` in 1: line valid, active high.
- `cam_vsync` in 1: frame blanking; high between frames.
- `pix_data` out 16: head-of-FIFO pixel, first byte in `[15:8]`.
- `pix_sof` out 1: head pixel is the first pixel of a frame.
- `pix_eol` out 1: head pixel is the last pixel of a line.
- `pix_valid` out 1: FIFO not empty.
- `pix_ready` in 1: consumer accepts the head pixel.
- `frame_done` out 1: single-cycle pulse at frame end.
- `line_count` out `LINE_CNT_W`: number of lines completed in the current frame.
- `overflow` out 1: sticky flag, set when a pixel is dropped because the FIFO is full.
- `overflow_clr` in 1: clears `overflow`.

## Operation
State machine `SYNC_WAIT`, `SYNC_LOW`, `FRAME`:
- `SYNC_WAIT` is the reset state.
  - Ignore all bus activity.
  - Move to `SYNC_LOW` when `cam_vsync` = 1.
- `SYNC_LOW`:
  - On `cam_vsync` = 0, move to `FRAME`.
  - On entry to `FRAME`: clear `line_count`, arm the SOF flag, clear the byte phase.
- `FRAME`:
  - Each cycle with `cam_href` = 1 is one byte.
  - Phase 0: latch the byte as the high byte.
  - Phase 1: form a pixel and toggle phase.
- Holding register (one-pixel delay, so EOL can be marked):
  - When a completed pixel arrives and the register already holds one, push the held pixel with eol = 0, then load the new pixel.
  - The SOF flag is attached to the first pixel loaded, then disarmed.
- Falling edge of `cam_href` (previous cycle 1, current cycle 0):
  - Push the held pixel with eol = 1 and empty the holding register.
  - Increment `line_count`, saturating at all-ones.
  - A dangling phase-1 byte (odd byte count) is discarded and phase resets to 0.
- Rising edge of `cam_vsync` in `FRAME`:
  - Pulse `frame_done`.
  - If `cam_href` was high (abnormal), flush the held pixel with eol = 1 and drop any partial byte.
  - Move to `SYNC_LOW`.
- FIFO: entries are 18 bits, `{sof, eol, data}`, first-word-fall-through.
  - Push when not full, or when full with a pop in the same cycle.
  - Otherwise drop the pixel and set `overflow`.
- `overflow`: if `overflow_clr` is asserted in the same cycle as a drop, set wins.
- Pop condition: `pix_valid & pix_ready`.

## Timing
- Reset values: `pix_valid` = 0, `pix_data` = 0, `pix_sof` = 0, `pix_eol` = 0, `frame_done` = 0, `line_count` = 0, `overflow` = 0. FIFO empty, holding register empty, phase 0, state `SYNC_WAIT`.
- Reset asserted mid-frame discards all data; capture restarts only after a complete vsync high→low.
- Second byte sampled at cycle N → pixel in the holding register at N+1.
- Push occurs on the next pixel completion or on the `href` fall. `pix_valid` and data appear the cycle after the push.
- `frame_done` is asserted the cycle after `cam_vsync` is first sampled high.
- A push and an `href`-fall push cannot coincide, since no byte is accepted while `href` = 0. At most one push per cycle.
- Edge detection uses one registered copy of `cam_href` and of `cam_vsync`.

## Configuration
- `CAM_CAPTURE_DECIMATE_EN` defined: 2:1 decimation in both axes.
  - Only pixels with even in-line index on lines with even `line_count` (LSB = 0) are kept.
  - `eol` marks the last kept pixel of a kept line.
  - `line_count` still counts every line.
  - `sof` goes on the first kept pixel.
- Undefined: every pixel is kept.

## Test plan
- Reset deasserted while `vsync` = 0 with `href` toggling → no `pix_valid` until `vsync` goes 1→0. The next line then delivers pixels.
- Frame of 2 lines × 6 bytes (0x12,0x34,0x56,0x78,0x9A,0xBC per line), `pix_ready` = 1:
  - Output 0x1234(sof), 0x5678, 0x9ABC(eol), 0x1234, 0x5678, 0x9ABC(eol).
  - `line_count` = 2.
  - `frame_done` pulses once after `vsync` rises.
- Line of 5 bytes → 2 pixels, second with eol. The fifth byte is dropped and the next line starts at phase 0.
- `FIFO_DEPTH` = 4, `pix_ready` = 0, one 12-byte line:
  - Pixels 1–4 are stored; pixels 5–6 are dropped.
  - `overflow` = 1.
  - After `pix_ready` = 1: exactly 4 pixels, none with eol. `overflow_clr` → `overflow` = 0.
- FIFO full with pop and push in the same cycle → push accepted, count stays at `FIFO_DEPTH`, `overflow` stays 0.
- With `CAM_CAPTURE_DECIMATE_EN`, 4 lines × 8 bytes:
  - Lines 0 and 2 output pixels 0 and 2.
  - Pixel 2 carries eol.
  - The first output carries sof.
  - Nothing is output from lines 1 and 3.
